// File: rtl/lcd_multi_channel_formatter.sv
// Renders NUM_CH packed channel values as decimal or hex ASCII fields and streams
// them to a character-LCD driver as address/code pairs, rate-limited between frames.
module lcd_multi_channel_formatter #(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 10,
  parameter int DIGITS      = 4,
  parameter int REFRESH_CYC = 2500000
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_CH*DATA_W-1:0] DataIn,
  input  logic                     HexMode,
  input  logic                     ForceUpdate,
  output logic                     CharValid,
  input  logic                     CharReady,
  output logic [4:0]               CharAddr,
  output logic [7:0]               CharCode,
  output logic                     FrameDone,
  output logic                     Busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = $clog2(DIGITS + 1);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int RC_W  = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int BCD_W = 4 * DIGITS;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] acc;
    acc = 64'd1;
    for (int k = 0; k < n; k++) acc = acc * 64'd10;
    return acc;
  endfunction

  localparam logic [63:0] DEC_LIMIT = pow10(DIGITS);

  // One double-dabble correction step: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] o;
    o = b;
    for (int k = 0; k < DIGITS; k++)
      if (o[4*k +: 4] >= 4'd5) o[4*k +: 4] = o[4*k +: 4] + 4'd3;
    return o;
  endfunction

  function automatic logic [DATA_W-1:0] chan_of(input logic [NUM_CH*DATA_W-1:0] v,
                                                input logic [CH_W-1:0] c);
    return v[int'(c) * DATA_W +: DATA_W];
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_EMIT, S_DONE} state_t;

  state_t                   r_state;
  logic [NUM_CH*DATA_W-1:0] r_snap;
  logic                     r_mode;
  logic                     r_pend;
  logic [RC_W-1:0]          r_rcnt;
  logic [CH_W-1:0]          r_ch;
  logic [BIT_W-1:0]         r_bitcnt;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_lead;
  logic                     r_valid;
  logic [4:0]               r_addr;
  logic [7:0]               r_code;
  logic                     r_done;
  logic [DATA_W-1:0]        r_val;
  logic [DATA_W-1:0]        r_sh;
  logic [BCD_W-1:0]         r_bcd;

  logic [63:0]              w_val_ext;
  logic [IDX_W-1:0]         w_pos;
  logic [3:0]               w_bcd_dig;
  logic [3:0]               w_hex_nib;
  logic                     w_ovf;
  logic                     w_blank;
  logic [7:0]               w_char;
  logic [4:0]               w_addr;
  logic                     w_last_char;
  logic                     w_last_ch;
  logic                     w_ch_start;
  logic [DATA_W-1:0]        w_next_val;
  logic [BCD_W-1:0]         w_bcd_adj;

  assign CharValid = r_valid;
  assign CharAddr  = r_addr;
  assign CharCode  = r_code;
  assign FrameDone = r_done;
  assign Busy      = (r_state != S_IDLE);

  // Character selection: w_pos is the digit weight of the character about to be shown.
  assign w_val_ext = 64'(r_val);
  assign w_pos     = IDX_W'(DIGITS - 1) - r_idx;
  assign w_bcd_dig = r_bcd[4*w_pos +: 4];
  assign w_hex_nib = w_val_ext[4*w_pos +: 4];
  assign w_ovf     = r_mode ? ((w_val_ext >> BCD_W) != 64'd0) : (w_val_ext >= DEC_LIMIT);
  assign w_blank   = !w_ovf && !r_mode && r_lead && (w_bcd_dig == 4'd0) && (w_pos != '0);
  assign w_addr    = 5'(int'(r_ch) * (DIGITS + 1) + int'(r_idx));

  always_comb begin
    w_char = 8'h20;
    if (w_ovf)
      w_char = 8'h2A;
    else if (r_mode)
      w_char = (w_hex_nib < 4'd10) ? (8'h30 + {4'd0, w_hex_nib}) : (8'h37 + {4'd0, w_hex_nib});
    else if (!w_blank)
      w_char = 8'h30 + {4'd0, w_bcd_dig};
  end

  assign w_last_char = (r_idx == IDX_W'(DIGITS));
  assign w_last_ch   = (r_ch == CH_W'(NUM_CH - 1));
  assign w_ch_start  = (r_state == S_LOAD) ||
                       ((r_state == S_EMIT) && !r_valid && w_last_char && !w_last_ch);
  assign w_next_val  = (r_state == S_LOAD) ? chan_of(DataIn, '0) : chan_of(r_snap, r_ch + 1'b1);
  assign w_bcd_adj   = dd_adjust(r_bcd);

  // Conversion datapath: loaded at each channel start, shifted once per CONV cycle.
  always_ff @(posedge Clk) begin
    if (w_ch_start) begin
      r_val <= w_next_val;
      r_sh  <= w_next_val;
      r_bcd <= '0;
    end else if ((r_state == S_CONV) && !r_mode) begin
      r_bcd <= {w_bcd_adj[BCD_W-2:0], r_sh[DATA_W-1]};
      r_sh  <= r_sh << 1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state  <= S_IDLE;
      r_snap   <= '0;
      r_mode   <= 1'b0;
      r_pend   <= 1'b1;
      r_rcnt   <= '0;
      r_ch     <= '0;
      r_bitcnt <= '0;
      r_idx    <= '0;
      r_lead   <= 1'b1;
      r_valid  <= 1'b0;
      r_addr   <= '0;
      r_code   <= 8'h20;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_rcnt != '0) r_rcnt <= r_rcnt - 1'b1;
      if (ForceUpdate || (DataIn != r_snap) || (HexMode != r_mode)) r_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_pend && (r_rcnt == '0)) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_snap   <= DataIn;
          r_mode   <= HexMode;
          r_ch     <= '0;
          r_bitcnt <= '0;
          r_pend   <= ForceUpdate;
          r_state  <= S_CONV;
        end
        S_CONV: begin
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_mode || (r_bitcnt == BIT_W'(DATA_W - 1))) begin
            r_idx   <= '0;
            r_lead  <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          // Alternate present / accept so a new character follows each acceptance by one cycle.
          if (r_valid) begin
            if (CharReady) begin
              r_valid <= 1'b0;
              r_idx   <= r_idx + 1'b1;
            end
          end else if (w_last_char) begin
            if (w_last_ch) begin
              r_state <= S_DONE;
            end else begin
              r_ch     <= r_ch + 1'b1;
              r_bitcnt <= '0;
              r_state  <= S_CONV;
            end
          end else begin
            r_valid <= 1'b1;
            r_addr  <= w_addr;
            r_code  <= w_char;
            r_lead  <= w_blank;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_rcnt  <= RC_W'(REFRESH_CYC - 1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_multi_channel_formatter.sv
// Directed + randomized bench for lcd_multi_channel_formatter; expected characters
// come from an arithmetic reference of the display rules.
module tb_lcd_multi_channel_formatter;

  localparam int R = 40;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [19:0] DataIn;
  logic        HexMode, ForceUpdate, CharReady;
  logic        CharValid, FrameDone, Busy;
  logic [4:0]  CharAddr;
  logic [7:0]  CharCode;

  logic [19:0] DataIn3;
  logic        HexMode3, Force3, CharReady3;
  logic        CharValid3, FrameDone3, Busy3;
  logic [4:0]  CharAddr3;
  logic [7:0]  CharCode3;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, fd_cnt = 0, fd3_cnt = 0, fd_cyc = 0, busy_rise = 0, busy_len = 0;
  bit prev_stall = 0, prev_busy = 0, rdy_rand = 0;
  logic [4:0]  st_addr;
  logic [7:0]  st_code;
  logic [12:0] q[$];
  logic [12:0] q3[$];

  always #5 Clk = ~Clk;

  lcd_multi_channel_formatter #(.NUM_CH(2), .DATA_W(10), .DIGITS(4), .REFRESH_CYC(R)) dut (
    .Clk(Clk), .Rst(Rst), .DataIn(DataIn), .HexMode(HexMode), .ForceUpdate(ForceUpdate),
    .CharValid(CharValid), .CharReady(CharReady), .CharAddr(CharAddr), .CharCode(CharCode),
    .FrameDone(FrameDone), .Busy(Busy));

  lcd_multi_channel_formatter #(.NUM_CH(2), .DATA_W(10), .DIGITS(3), .REFRESH_CYC(R)) dut3 (
    .Clk(Clk), .Rst(Rst), .DataIn(DataIn3), .HexMode(HexMode3), .ForceUpdate(Force3),
    .CharValid(CharValid3), .CharReady(CharReady3), .CharAddr(CharAddr3), .CharCode(CharCode3),
    .FrameDone(FrameDone3), .Busy(Busy3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Display rule for one character of a field, straight from value arithmetic.
  function automatic logic [7:0] char_of(input int v, input bit hex, input int dg, input int i);
    int base, p, pw, lim, d;
    base = hex ? 16 : 10;
    p    = dg - 1 - i;
    lim  = 1;
    for (int k = 0; k < dg; k++) lim = lim * base;
    pw = 1;
    for (int k = 0; k < p; k++) pw = pw * base;
    if (v >= lim) return 8'h2A;
    if (!hex && p > 0 && v < pw) return 8'h20;
    d = (v / pw) % base;
    return (d < 10) ? 8'(8'h30 + d) : 8'(8'h41 + d - 10);
  endfunction

  // One clock: observe at the falling edge, then drive just after the rising edge.
  task automatic tick();
    @(negedge Clk);
    cyc++;
    if (prev_stall) chk("stall_hold", 32'({CharValid, CharAddr, CharCode}), 32'({1'b1, st_addr, st_code}));
    prev_stall = CharValid && !CharReady;
    st_addr    = CharAddr;
    st_code    = CharCode;
    if (CharValid && CharReady) q.push_back({CharAddr, CharCode});
    if (CharValid3) q3.push_back({CharAddr3, CharCode3});
    if (FrameDone) begin fd_cnt++; fd_cyc = cyc; end
    if (FrameDone3) fd3_cnt++;
    if (Busy && !prev_busy) begin busy_rise = cyc; busy_len = 0; end
    if (Busy) busy_len++;
    prev_busy = Busy;
    @(posedge Clk);
    #2;
    if (rdy_rand) CharReady = ($urandom_range(0, 99) < 30);
  endtask

  task automatic wait_frame(input string tag, input int max);
    int start;
    start = fd_cnt;
    for (int k = 0; k < max && fd_cnt == start; k++) tick();
    chk({tag, "_done"}, 32'(fd_cnt != start), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [19:0] din, input bit hex,
                             input int dg, input bit use3);
    logic [12:0] got, exp;
    int n;
    n = use3 ? q3.size() : q.size();
    chk({tag, "_count"}, 32'(n), 32'(2 * dg));
    for (int ch = 0; ch < 2; ch++) begin
      for (int i = 0; i < dg; i++) begin
        exp = {5'(ch * (dg + 1) + i), char_of(int'(din[ch*10 +: 10]), hex, dg, i)};
        got = 13'h1FFF;
        if (use3) begin
          if (q3.size() > 0) got = q3.pop_front();
        end else begin
          if (q.size() > 0) got = q.pop_front();
        end
        chk({tag, "_char"}, 32'(got), 32'(exp));
      end
    end
    if (use3) q3.delete(); else q.delete();
  endtask

  initial begin
    logic [19:0] old;
    int n0, fd1;
    Rst = 1'b1; DataIn = {10'd0, 10'd37}; HexMode = 1'b0; ForceUpdate = 1'b0; CharReady = 1'b1;
    DataIn3 = {10'd5, 10'd1000}; HexMode3 = 1'b0; Force3 = 1'b0; CharReady3 = 1'b1;
    tick();
    Rst = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(CharValid), 32'd0);
    chk("rst_addr",  32'(CharAddr),  32'd0);
    chk("rst_code",  32'(CharCode),  32'h20);
    chk("rst_done",  32'(FrameDone), 32'd0);
    chk("rst_busy",  32'(Busy),      32'd0);

    // Forced first frame after reset, plus the 3-digit overflow instance.
    Rst = 1'b1;
    q.delete(); q3.delete(); fd_cnt = 0; fd3_cnt = 0;
    wait_frame("t1", 200);
    chk("t1_busy_len", 32'(busy_len), 32'd40);
    check_frame("t1", DataIn, 1'b0, 4, 1'b0);
    chk("t1_fd_once", 32'(fd_cnt), 32'd1);
    chk("t1_d3_fd", 32'(fd3_cnt), 32'd1);
    check_frame("t1_d3", DataIn3, 1'b0, 3, 1'b1);

    // Unchanged inputs stay quiet; a force pulse repeats the frame.
    n0 = fd_cnt;
    repeat (3 * R) tick();
    chk("t2_quiet_chars", 32'(q.size()), 32'd0);
    chk("t2_quiet_fd", 32'(fd_cnt), 32'(n0));
    ForceUpdate = 1'b1; tick(); ForceUpdate = 1'b0;
    wait_frame("t2", 300);
    check_frame("t2", DataIn, 1'b0, 4, 1'b0);

    // Hex rendering, then a mode-only change back to decimal.
    DataIn = {10'h0A5, 10'h3FF}; HexMode = 1'b1;
    wait_frame("t3_hex", 300);
    check_frame("t3_hex", DataIn, 1'b1, 4, 1'b0);
    HexMode = 1'b0;
    wait_frame("t3_dec", 300);
    check_frame("t3_dec", DataIn, 1'b0, 4, 1'b0);

    // Random values and modes under a 30% ready duty cycle.
    rdy_rand = 1;
    for (int it = 0; it < 8; it++) begin
      DataIn  = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
      HexMode = 1'($urandom_range(0, 1));
      ForceUpdate = 1'b1; tick(); ForceUpdate = 1'b0;
      wait_frame("t4", 2000);
      check_frame("t4", DataIn, HexMode, 4, 1'b0);
    end
    rdy_rand = 0; CharReady = 1'b1;
    tick();

    // Mid-frame change lands in the next frame, exactly one refresh interval later.
    HexMode = 1'b0; q.delete();
    DataIn = {10'd512, 10'd88};
    for (int k = 0; k < 300 && q.size() < 2; k++) tick();
    chk("t5_mid", 32'(q.size() >= 2), 32'd1);
    old = DataIn;
    DataIn[19:10] = 10'd7;
    wait_frame("t5_old", 300);
    check_frame("t5_old", old, 1'b0, 4, 1'b0);
    fd1 = fd_cyc;
    wait_frame("t5_new", 300);
    check_frame("t5_new", DataIn, 1'b0, 4, 1'b0);
    chk("t5_gap", 32'(busy_rise - fd1), 32'(R));

    // Reset in the middle of the second channel's conversion.
    q.delete();
    DataIn = {10'd999, 10'd4};
    for (int k = 0; k < 300 && q.size() < 4; k++) tick();
    chk("t6_mid", 32'(q.size() >= 4), 32'd1);
    tick(); tick(); tick();
    Rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(CharValid), 32'd0);
    chk("t6_rst_addr",  32'(CharAddr),  32'd0);
    chk("t6_rst_code",  32'(CharCode),  32'h20);
    chk("t6_rst_done",  32'(FrameDone), 32'd0);
    chk("t6_rst_busy",  32'(Busy),      32'd0);
    chk("t6_rst_busy3", 32'(Busy3),     32'd0);
    tick(); tick();
    Rst = 1'b1;
    q.delete(); q3.delete();
    wait_frame("t6", 300);
    check_frame("t6", DataIn, 1'b0, 4, 1'b0);
    check_frame("t6_d3", DataIn3, 1'b0, 3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
